// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default reset
// vector and the monitor request slot assignments.
package reset_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ASSERT = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;

  localparam logic [15:0] RESET_HANDLER_DEF = 16'hFFFE;

  // Request slots; the lowest index wins when several monitors fire together.
  localparam int REQ_POR  = 0;
  localparam int REQ_ATOM = 1;
  localparam int REQ_KEY  = 2;
  localparam int REQ_DMA  = 3;

endpackage

// File: rtl/reset_sequencer_if.sv
// Monitor-side bundle of the reset sequencer: request/PC inputs and the
// reset, status and cause outputs.
interface reset_sequencer_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [15:0]     pc;
  logic [NREQ-1:0] req;
  logic            res;
  logic            busy;
  logic [NREQ-1:0] cause;
  logic [IDW-1:0]  first_id;
  logic            timeout;
  logic [7:0]      rst_count;

  modport master (
    output pc, req,
    input  res, busy, cause, first_id, timeout, rst_count
  );

  modport slave (
    input  pc, req,
    output res, busy, cause, first_id, timeout, rst_count
  );

endinterface

// File: rtl/reset_prio_enc.sv
// Lowest-index-first priority encoder; returns 0 when no request is set.
module reset_prio_enc #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  output logic [IDW-1:0]  id_o
);

  always_comb begin
    id_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IDW'(i);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Merges monitor violation requests into one core reset with a minimum hold,
// then waits for the reset-vector fetch and re-asserts if it never comes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | core running, no episode open; cause/first_id/timeout held
// ST_ASSERT | res high; cnt counts down the remaining hold cycles
// ST_WAIT   | res low; cnt counts up until vector fetch or timeout
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int          NREQ          = 4,
  parameter int          HOLD_CYCLES   = 8,
  parameter int          WAIT_TIMEOUT  = 16,
  parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF,
  parameter int          IDW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic              clk,
  input logic              reset_n,
  reset_sequencer_if.slave bus
);

  localparam int CMAX = (HOLD_CYCLES > WAIT_TIMEOUT) ? HOLD_CYCLES : WAIT_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] cause_q, cause_d;
  logic [IDW-1:0]  first_id_q, first_id_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      rst_count_q, rst_count_d;

  logic [IDW-1:0]  enc_id;
  logic            any_req;
  logic            vec_fetch;

  reset_prio_enc #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_prio_enc (
    .req_i (bus.req),
    .id_o  (enc_id)
  );

  assign any_req   = |bus.req;
  assign vec_fetch = (bus.pc == RESET_HANDLER);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    first_id_d  = first_id_q;
    timeout_d   = timeout_q;
    rst_count_d = rst_count_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d    = ST_ASSERT;
          cnt_d      = HOLD_LD;
          cause_d    = bus.req;
          first_id_d = enc_id;
          timeout_d  = 1'b0;
          if (rst_count_q != 8'hFF) rst_count_d = rst_count_q + 8'd1;
        end
      end

      ST_ASSERT: begin
        if (any_req) begin
          cause_d = cause_q | bus.req;
          cnt_d   = HOLD_LD;
        end else if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WAIT: begin
        // A fresh request outranks a vector fetch seen in the same cycle.
        if (any_req) begin
          state_d = ST_ASSERT;
          cause_d = cause_q | bus.req;
          cnt_d   = HOLD_LD;
        end else if (vec_fetch) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d   = ST_ASSERT;
          timeout_d = 1'b1;
          cnt_d     = HOLD_LD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = HOLD_LD;
      end
    endcase
  end

  // Power-on is itself an episode, but it is not counted in rst_count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= HOLD_LD;
      cause_q     <= '0;
      first_id_q  <= '0;
      timeout_q   <= 1'b0;
      rst_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      first_id_q  <= first_id_d;
      timeout_q   <= timeout_d;
      rst_count_q <= rst_count_d;
    end
  end

  assign bus.res       = (state_q == ST_ASSERT);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cause     = cause_q;
  assign bus.first_id  = first_id_q;
  assign bus.timeout   = timeout_q;
  assign bus.rst_count = rst_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: an episode-level model checked every cycle,
// directed scenarios with literal expectations, and a random phase.
module tb_reset_sequencer;

  localparam int          NREQ  = 4;
  localparam int          IDW   = 2;
  localparam int          HOLD  = 8;
  localparam int          WTO   = 16;
  localparam logic [15:0] VEC   = 16'hFFFE;

  logic clk = 1'b0;
  logic reset_n;
  bit   chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  reset_sequencer_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  reset_sequencer #(
    .NREQ          (NREQ),
    .HOLD_CYCLES   (HOLD),
    .WAIT_TIMEOUT  (WTO),
    .RESET_HANDLER (VEC),
    .IDW           (IDW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Episode model: m_left = res-high cycles still owed (including current),
  // m_age = WAIT cycles already spent.
  bit              m_busy, m_wait, m_timeout;
  int              m_left, m_age, m_count;
  logic [NREQ-1:0] m_cause;
  int              m_first;

  task automatic model_reset();
    m_busy = 1; m_wait = 0; m_left = HOLD; m_age = 0;
    m_cause = '0; m_first = 0; m_timeout = 0; m_count = 0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] r;
    r = bus.req;
    if (!reset_n) return;
    if (!m_busy) begin
      if (r != 0) begin
        m_busy = 1; m_wait = 0; m_left = HOLD;
        m_cause = r;
        m_first = $clog2(int'(r & (~r + 4'd1)));
        m_timeout = 0;
        if (m_count < 255) m_count++;
      end
    end else if (!m_wait) begin
      if (r != 0) begin
        m_cause |= r; m_left = HOLD;
      end else begin
        m_left--;
        if (m_left == 0) begin m_wait = 1; m_age = 0; end
      end
    end else begin
      if (r != 0) begin
        m_wait = 0; m_left = HOLD; m_cause |= r;
      end else if (bus.pc == VEC) begin
        m_busy = 0;
      end else begin
        m_age++;
        if (m_age == WTO) begin m_wait = 0; m_left = HOLD; m_timeout = 1; end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("res",       int'(bus.res),       int'(m_busy && !m_wait));
      check("busy",      int'(bus.busy),      int'(m_busy));
      check("cause",     int'(bus.cause),     int'(m_cause));
      check("first_id",  int'(bus.first_id),  m_first);
      check("timeout",   int'(bus.timeout),   int'(m_timeout));
      check("rst_count", int'(bus.rst_count), m_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic measure_res(output int n);
    n = 0;
    for (int i = 0; i < 200 && bus.res; i++) begin
      n++;
      tick();
    end
  endtask

  task automatic go_idle();
    for (int i = 0; i < 100 && bus.busy; i++) begin
      bus.req = '0;
      bus.pc  = bus.res ? 16'h0000 : VEC;
      tick();
    end
    bus.pc = 16'h0000;
    check("reach_idle", int'(bus.busy), 0);
  endtask

  int n;

  initial begin
    reset_n = 1'b0;
    bus.req = '0;
    bus.pc  = 16'h0000;
    model_reset();
    chk_en = 1'b1;

    // Power-on
    repeat (3) tick();
    check("por_res_in_reset", int'(bus.res), 1);
    reset_n = 1'b1;
    measure_res(n);
    check("por_hold_len", n, 8);
    tick();
    tick();
    bus.pc = VEC;
    tick();
    bus.pc = 16'h0000;
    check("por_idle", int'(bus.busy), 0);
    check("por_count", int'(bus.rst_count), 0);

    // Single request
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    measure_res(n);
    check("single_hold_len", n, 8);
    check("single_cause", int'(bus.cause), 4'b0100);
    check("single_first", int'(bus.first_id), 2);
    check("single_count", int'(bus.rst_count), 1);
    go_idle();

    // Extension and priority
    bus.req = 4'b1010;
    tick();
    n = 0;
    for (int i = 0; i < 200 && bus.res; i++) begin
      n++;
      bus.req = (n == 5) ? 4'b0001 : 4'b0000;
      tick();
    end
    bus.req = '0;
    check("ext_hold_len", n, 13);
    check("ext_first", int'(bus.first_id), 1);
    check("ext_cause", int'(bus.cause), 4'b1011);

    // Timeout: no vector fetch
    n = 0;
    for (int i = 0; i < 200 && bus.busy && !bus.res; i++) begin
      n++;
      tick();
    end
    check("wait_len", n, 16);
    measure_res(n);
    check("timeout_hold_len", n, 8);
    check("timeout_flag", int'(bus.timeout), 1);
    check("timeout_count", int'(bus.rst_count), 2);
    go_idle();

    // Race: request and vector fetch together in WAIT
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    measure_res(n);
    bus.pc  = VEC;
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    bus.pc  = 16'h0000;
    check("race_res", int'(bus.res), 1);
    check("race_cause", int'(bus.cause), 4'b1001);
    check("race_timeout_cleared", int'(bus.timeout), 0);
    check("race_count", int'(bus.rst_count), 3);
    go_idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.req = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      bus.pc  = ($urandom_range(0, 7) == 0) ? VEC : 16'($urandom);
      tick();
    end
    bus.req = '0;
    go_idle();

    // Saturation
    for (int e = 0; e < 260; e++) begin
      bus.req = 4'($urandom_range(1, 15));
      tick();
      bus.req = '0;
      go_idle();
    end
    check("sat_count", int'(bus.rst_count), 255);

    // Asynchronous reset in WAIT
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    measure_res(n);
    check("pre_abort_busy", int'(bus.busy), 1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("abort_res", int'(bus.res), 1);
    check("abort_busy", int'(bus.busy), 1);
    check("abort_cause", int'(bus.cause), 0);
    check("abort_first", int'(bus.first_id), 0);
    check("abort_timeout", int'(bus.timeout), 0);
    check("abort_count", int'(bus.rst_count), 0);
    @(negedge clk);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Central reset controller for the hardware-monitor set: proof-of-reset, atomicity, key-access and DMA monitors each raise a violation request.
- Merges these requests, drives one system reset to the core for a guaranteed minimum hold time, then releases it and watches the PC until the core fetches the reset vector.
- Re-asserts reset if the vector fetch does not occur in time.
- Latches the cause of each reset episode for SW-Att logging.

Parameters:
- NREQ, 4: number of monitor request inputs.
- HOLD_CYCLES, 8: minimum cycles res stays high after the last request (>=1).
- WAIT_TIMEOUT, 16: maximum cycles in WAIT before forced re-assert (>=1).
- RESET_HANDLER, 16'hFFFE: PC value that marks a completed reset.
- IDW, $clog2(NREQ) (min 1): width of first_id.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- pc, input, 16: current core program counter.
- req, input, NREQ: level violation requests; bit 0 has the highest priority.
- res, output, 1: reset to the core, active high.
- busy, output, 1: episode in progress (ASSERT or WAIT).
- cause, output, NREQ: sticky OR of all requests seen in the current or last episode.
- first_id, output, IDW: index of the highest-priority request that opened the episode.
- timeout, output, 1: the last episode contained at least one WAIT timeout.
- rst_count, output, 8: number of episodes opened from IDLE, saturating at 255.

Behaviour:
- States: IDLE, ASSERT, WAIT. All outputs are Moore-style registered values.
  - res = (state == ASSERT).
  - busy = (state != IDLE).
- reset_n low, asynchronous:
  - state = ASSERT, hold counter = HOLD_CYCLES-1, res = 1, busy = 1.
  - cause = 0, first_id = 0, timeout = 0, rst_count = 0.
  - The power-on episode does not increment rst_count.
- IDLE, any req bit high at a posedge:
  - Next state ASSERT; res is high from the next cycle.
  - cause <= req (old value cleared); first_id <= priority encode of req.
  - timeout <= 0; rst_count++ (saturating).
- ASSERT:
  - Hold counter decrements each cycle.
  - Any req high: cause |= req and the counter reloads to HOLD_CYCLES-1. res therefore stays high for at least HOLD_CYCLES cycles after the last request.
  - Counter == 0 with no req: next state WAIT.
  - A single request with no further requests gives res high for exactly HOLD_CYCLES cycles.
- WAIT:
  - res = 0; the wait counter starts at 0 on entry and increments each cycle.
  - Priority order, highest first:
    1. Any req: ASSERT, cause |= req, counter reload.
    2. pc == RESET_HANDLER: IDLE.
    3. Wait counter == WAIT_TIMEOUT-1: ASSERT, timeout <= 1, counter reload.
  - Simultaneous req and vector fetch: req wins.
  - first_id and rst_count do not change on re-entry from WAIT.
- pc == RESET_HANDLER has no effect in IDLE or ASSERT.
- Counter widths: $clog2(max(HOLD_CYCLES, WAIT_TIMEOUT)+1). No wrap is possible because counters reload or saturate before overflow.
- cause, first_id and timeout hold their values in IDLE until the next episode opens.
- reset_n asserted mid-episode aborts the episode immediately and restores the reset values above.

Decomposition:
- Shared package reset_seq_pkg holds:
  - the state typedef (IDLE/ASSERT/WAIT, 2-bit);
  - the RESET_HANDLER default;
  - the request-index constants REQ_POR=0, REQ_ATOM=1, REQ_KEY=2, REQ_DMA=3.
- One sub-module, reset_prio_enc: combinational NREQ-to-IDW lowest-index-first encoder, output 0 when its input is 0.

Test Plan:
- Power-on: hold reset_n low 3 cycles, release, keep req = 0.
  - res high for 8 cycles, then WAIT.
  - pc = 16'hFFFE on cycle 3 of WAIT -> IDLE, busy = 0, rst_count = 0.
- Single request: from IDLE pulse req = 4'b0100 for 1 cycle.
  - res high exactly 8 cycles.
  - cause = 4'b0100, first_id = 2, rst_count = 1.
  - Vector fetch -> IDLE.
- Extension and priority: req = 4'b1010 at cycle 0, then req = 4'b0001 at ASSERT cycle 5.
  - first_id = 1, cause = 4'b1011.
  - res high for 5 + 8 = 13 cycles total.
- Timeout: after release, pc never reaches 16'hFFFE.
  - Exactly 16 WAIT cycles, then res re-asserts for 8 cycles, timeout = 1.
  - rst_count unchanged.
- Race: in WAIT drive pc = 16'hFFFE and req = 4'b0001 in the same cycle.
  - Next state ASSERT, cause bit 0 set.
- Saturation and mid-reset: open 260 episodes -> rst_count = 255.
  - Then pull reset_n low during WAIT -> all outputs return to reset values asynchronously.
